// File: rtl/pipe_hazard_ctrl.sv
// Hazard / stall control for a 5-stage pipeline (IF, ID, EX, ME, WB).
// It drives the stage-register enables and bubble selects, the PC enable
// and the branch redirect, and it runs the dmem request/ack handshake.
// The handshake is level based: dmemReq stays high until the cycle in
// which dmemAck is sampled high. That cycle completes the access.
// A watchdog moves the block to HALT if no ack arrives within TIMEOUT
// cycles of waiting.
// Optional macro HAZ_STALL_CNT_EN adds a saturating count of cycles with
// pcEn=0. When the macro is undefined, stallCount is tied to 0.
module pipe_hazard_ctrl #(
  parameter int OP_W    = 6,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  idOpCode,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic [OP_W-1:0]  exOpCode,
  input  logic [REG_W-1:0] exRd,
  input  logic [OP_W-1:0]  meOpCode,
  input  logic             meZero,
  input  logic             dmemAck,
  output logic             dmemReq,
  output logic             pcEn,
  output logic             pcSel,
  output logic             ifidEn,
  output logic             idexEn,
  output logic             exmeEn,
  output logic             mewbEn,
  output logic             ifidBubble,
  output logic             idexBubble,
  output logic             exmeBubble,
  output logic             mewbBubble,
  output logic             memErr,
  output logic [15:0]      stallCount,
  output logic [1:0]       state_dbg
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             mem_err_q, mem_err_d;

  logic mem_op;
  logic br_taken;
  logic id_uses_rt;
  logic load_use;

  // Decode the hazard conditions from the opcodes in ID, EX and ME.
  always_comb begin
    mem_op     = (meOpCode == OP_LW) || (meOpCode == OP_SW);
    br_taken   = ((meOpCode == OP_BEQ) && meZero) ||
                 ((meOpCode == OP_BNE) && !meZero);
    id_uses_rt = (idOpCode == OP_RTYPE) || (idOpCode == OP_BEQ) ||
                 (idOpCode == OP_BNE)   || (idOpCode == OP_SW);
    load_use   = (exOpCode == OP_LW) && (exRd != '0) &&
                 ((exRd == idRs) || ((exRd == idRt) && id_uses_rt));
  end

  // Register the state, the wait timer and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      timer_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Compute the next state and the pipeline controls. Reset forces every
  // enable and the request low right away, without waiting for a clock edge.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mem_err_d  = mem_err_q;
    dmemReq    = 1'b0;
    pcEn       = 1'b0;
    pcSel      = 1'b0;
    ifidEn     = 1'b0;
    idexEn     = 1'b0;
    exmeEn     = 1'b0;
    mewbEn     = 1'b0;
    ifidBubble = 1'b0;
    idexBubble = 1'b0;
    exmeBubble = 1'b0;
    mewbBubble = 1'b0;
    case (state_q)
      ST_RUN: begin
        dmemReq = mem_op;
        if (mem_op && !dmemAck) begin
          // The memory access needs extra cycles, so the whole pipe holds.
          state_d = ST_MEMWAIT;
          timer_d = TMR_W'(1);
        end else begin
          pcEn   = 1'b1;
          ifidEn = 1'b1;
          idexEn = 1'b1;
          exmeEn = 1'b1;
          mewbEn = 1'b1;
          if (br_taken) begin
            // Squash the three wrong-path instructions behind the branch.
            pcSel      = 1'b1;
            ifidBubble = 1'b1;
            idexBubble = 1'b1;
            exmeBubble = 1'b1;
          end else if (load_use) begin
            // Hold IF and ID for one cycle and insert a nop into EX.
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexBubble = 1'b1;
          end
        end
      end
      ST_MEMWAIT: begin
        dmemReq = 1'b1;
        if (dmemAck) begin
          pcEn    = 1'b1;
          ifidEn  = 1'b1;
          idexEn  = 1'b1;
          exmeEn  = 1'b1;
          mewbEn  = 1'b1;
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d   = ST_HALT;
          mem_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_HALT: begin
        // The pipe stays frozen. Only a reset leaves this state.
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
    if (!rst_n) begin
      dmemReq = 1'b0;
      pcEn    = 1'b0;
      pcSel   = 1'b0;
      ifidEn  = 1'b0;
      idexEn  = 1'b0;
      exmeEn  = 1'b0;
      mewbEn  = 1'b0;
    end
  end

  assign memErr    = mem_err_q;
  assign state_dbg = state_q;

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pcEn && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Register the stall count. Reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`else
  assign stallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl, instantiated with TIMEOUT=4.
// Each comparison point packs the control outputs into one 12-bit vector:
// {pcEn,pcSel,ifidEn,idexEn,exmeEn,mewbEn,ifidB,idexB,exmeB,mewbB,dmemReq,memErr}
module tb_pipe_hazard_ctrl;

  localparam logic [11:0] V_RST    = 12'b0_0_0000_0000_0_0;
  localparam logic [11:0] V_RUN    = 12'b1_0_1111_0000_0_0;
  localparam logic [11:0] V_RUNREQ = 12'b1_0_1111_0000_1_0;
  localparam logic [11:0] V_LU     = 12'b0_0_0111_0100_0_0;
  localparam logic [11:0] V_BR     = 12'b1_1_1111_1110_0_0;
  localparam logic [11:0] V_FRZ    = 12'b0_0_0000_0000_1_0;
  localparam logic [11:0] V_HALT   = 12'b0_0_0000_0000_0_1;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  idOpCode, exOpCode, meOpCode;
  logic [4:0]  idRs, idRt, exRd;
  logic        meZero, dmemAck;
  logic        dmemReq, pcEn, pcSel, memErr;
  logic        ifidEn, idexEn, exmeEn, mewbEn;
  logic        ifidBubble, idexBubble, exmeBubble, mewbBubble;
  logic [15:0] stallCount;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.OP_W(6), .REG_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .idOpCode(idOpCode), .idRs(idRs), .idRt(idRt),
    .exOpCode(exOpCode), .exRd(exRd),
    .meOpCode(meOpCode), .meZero(meZero), .dmemAck(dmemAck),
    .dmemReq(dmemReq), .pcEn(pcEn), .pcSel(pcSel),
    .ifidEn(ifidEn), .idexEn(idexEn), .exmeEn(exmeEn), .mewbEn(mewbEn),
    .ifidBubble(ifidBubble), .idexBubble(idexBubble),
    .exmeBubble(exmeBubble), .mewbBubble(mewbBubble),
    .memErr(memErr), .stallCount(stallCount), .state_dbg(state_dbg)
  );

  // Driver task: applies one set of pipeline-stage inputs.
  task automatic drive(input logic [5:0] id_op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [5:0] ex_op,
                       input logic [4:0] rd, input logic [5:0] me_op,
                       input logic zero, input logic ack);
    idOpCode = id_op; idRs = rs; idRt = rt;
    exOpCode = ex_op; exRd = rd;
    meOpCode = me_op; meZero = zero; dmemAck = ack;
  endtask

  // Applies neutral R-type traffic with no hazards.
  task automatic drive_idle(input logic ack);
    drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h00, 1'b0, ack);
  endtask

  // Checks the control vector and the stall counter, then advances the
  // expected stall count for the clock edge that follows.
  task automatic chk(input string tag, input logic [11:0] exp_v);
    logic [11:0] obs_v;
    logic [15:0] exp_cnt;
    obs_v = {pcEn, pcSel, ifidEn, idexEn, exmeEn, mewbEn,
             ifidBubble, idexBubble, exmeBubble, mewbBubble, dmemReq, memErr};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_v, exp_v);
    end
`ifdef HAZ_STALL_CNT_EN
    exp_cnt = 16'(exp_stall);
`else
    exp_cnt = 16'h0000;
`endif
    checks++;
    assert (stallCount === exp_cnt) else begin
      failures++;
      $error("FAIL %s stallCount observed=%0d expected=%0d", tag, stallCount, exp_cnt);
    end
    if (rst_n && !exp_v[11]) exp_stall++;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp_s);
    checks++;
    assert (state_dbg === exp_s) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, exp_s);
    end
  endtask

  // Directed sequence, driven at the falling edge and checked 1 ns later.
  initial begin
    rst_n = 1'b0;
    drive_idle(1'b0);
    #1;
    exp_stall = 0;
    chk("reset", V_RST);
    chk_state("reset_state", S_RUN);

    @(negedge clk); rst_n = 1'b1; drive_idle(1'b0); #1;
    chk("run_default", V_RUN);

    // Load-use hazards.
    @(negedge clk); drive(6'h00, 5'd8, 5'd2, 6'h23, 5'd8, 6'h00, 1'b0, 1'b0); #1;
    chk("lu_rs", V_LU);
    @(negedge clk); drive_idle(1'b0); #1;
    chk("lu_after", V_RUN);
    @(negedge clk); drive(6'h00, 5'd0, 5'd0, 6'h23, 5'd0, 6'h00, 1'b0, 1'b0); #1;
    chk("lu_rd0", V_RUN);
    @(negedge clk); drive(6'h2B, 5'd1, 5'd9, 6'h23, 5'd9, 6'h00, 1'b0, 1'b0); #1;
    chk("lu_rt_sw", V_LU);
    @(negedge clk); drive(6'h23, 5'd1, 5'd9, 6'h23, 5'd9, 6'h00, 1'b0, 1'b0); #1;
    chk("lu_rt_lw_none", V_RUN);

    // Branches resolved in ME.
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h04, 1'b1, 1'b0); #1;
    chk("beq_taken", V_BR);
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h04, 1'b0, 1'b0); #1;
    chk("beq_not", V_RUN);
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h05, 1'b0, 1'b0); #1;
    chk("bne_taken", V_BR);
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h05, 1'b1, 1'b0); #1;
    chk("bne_not", V_RUN);
    @(negedge clk); drive(6'h00, 5'd4, 5'd2, 6'h23, 5'd4, 6'h04, 1'b1, 1'b0); #1;
    chk("br_over_lu", V_BR);

    // Zero-wait access, then a memory freeze that overrides a load-use.
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h23, 1'b0, 1'b1); #1;
    chk("zero_wait", V_RUNREQ);
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h00, 1'b0, 1'b0); #1;
    chk_state("zero_wait_state", S_RUN);

    // Store with a 3-cycle wait.
    @(negedge clk); drive(6'h00, 5'd6, 5'd2, 6'h23, 5'd6, 6'h2B, 1'b0, 1'b0); #1;
    chk("mw_frz1", V_FRZ);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("mw_frz", V_FRZ);
      chk_state("mw_state", S_WAIT);
    end
    @(negedge clk); dmemAck = 1'b1; #1;
    chk("mw_ack", V_RUNREQ);
    @(negedge clk); drive_idle(1'b0); #1;
    chk("mw_done", V_RUN);
    chk_state("mw_done_state", S_RUN);

    // Watchdog: load that is never acknowledged.
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h23, 1'b0, 1'b0); #1;
    chk("wd_w1", V_FRZ);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("wd_w", V_FRZ);
    end
    @(negedge clk); #1;
    chk("wd_halt", V_HALT);
    chk_state("wd_halt_state", S_HALT);
    @(negedge clk); dmemAck = 1'b1; #1;
    chk("wd_halt_ack", V_HALT);
    rst_n = 1'b0; drive_idle(1'b0); #1;
    exp_stall = 0;
    chk("wd_reset", V_RST);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("wd_release", V_RUN);

    // Asynchronous reset in the middle of a wait.
    @(negedge clk); drive(6'h00, 5'd1, 5'd2, 6'h00, 5'd3, 6'h2B, 1'b0, 1'b0); #1;
    chk("ar_frz1", V_FRZ);
    @(negedge clk); #1;
    chk("ar_frz2", V_FRZ);
    chk_state("ar_wait", S_WAIT);
    #2; rst_n = 1'b0; #1;
    exp_stall = 0;
    chk("ar_in_reset", V_RST);
    chk_state("ar_state", S_RUN);
    @(negedge clk); rst_n = 1'b1; drive_idle(1'b0); #1;
    chk("ar_release", V_RUN);
    chk_state("ar_release_state", S_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control block for the 5-stage pipeline; drives the en and bubbleSel inputs of the IF/ID, ID/EX, EX/ME and ME/WB stage registers, plus the PC enable and branch redirect.
- Detects load-use hazards, taken branches resolved in ME, and multi-cycle data-memory accesses.
- Runs the dmem request/acknowledge handshake, with a watchdog that halts the pipe on a hung access.

Parameters:
- OP_W, 6, opcode width
- REG_W, 5, register index width
- TIMEOUT, 64, max cycles waiting for dmemAck before error (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- idOpCode  in  OP_W  opcode of instruction in ID (IF/ID instr[31:26])
- idRs  in  REG_W  rs field in ID (instr[25:21])
- idRt  in  REG_W  rt field in ID (instr[20:16])
- exOpCode  in  OP_W  opcode in EX (ID/EX opCode output)
- exRd  in  REG_W  destination register in EX (ID/EX rd output)
- meOpCode  in  OP_W  opcode in ME (EX/ME opCode output)
- meZero  in  1  ALU zero flag in ME (EX/ME zero output)
- dmemAck  in  1  data memory completes the current access
- dmemReq  out  1  data memory access request
- pcEn  out  1  PC register load enable
- pcSel  out  1  1 = load branch target into PC
- ifidEn, idexEn, exmeEn, mewbEn  out  1 each  stage register enables
- ifidBubble, idexBubble, exmeBubble, mewbBubble  out  1 each  stage loads all-zero nop when en=1
- memErr  out  1  sticky watchdog error
- stallCount  out  16  stall cycle counter (see Optional Feature)

Behaviour:
- Opcodes: R-type 6'h00, LW 6'h23, SW 6'h2B, BEQ 6'h04, BNE 6'h05. memOp = meOpCode is LW or SW.
- States: RUN, MEMWAIT, HALT. Encoding is free.
- Reset (async, rst_n=0):
  - state=RUN, timer=0, memErr=0, stallCount=0.
  - Outputs are combinational from state and inputs. While in reset, all enables are 0 and dmemReq=0.
- RUN default: all en=1, all bubbles=0, pcEn=1, pcSel=0, dmemReq=memOp.
- RUN, memOp=1 and dmemAck=0:
  - Freeze: pcEn=0, all four stage en=0, bubbles=0.
  - Next state=MEMWAIT, timer=1.
- RUN, memOp=1 and dmemAck=1: zero-wait access; pipe advances normally and state stays RUN.
- Branch taken = (meOpCode=BEQ & meZero) | (meOpCode=BNE & !meZero).
  - In RUN, pcSel=1 and pcEn=1.
  - ifidBubble=idexBubble=exmeBubble=1 with en=1, squashing the 3 wrong-path instructions.
  - ME/WB advances normally.
- Load-use hazard:
  - Condition: exOpCode=LW, exRd!=0, and either exRd=idRs, or exRd=idRt with idOpCode in {R-type, BEQ, BNE, SW}.
  - In RUN with no taken branch: pcEn=0, ifidEn=0, idexEn=1 with idexBubble=1; EX/ME and ME/WB advance.
  - Lasts exactly 1 cycle, because EX holds a nop afterwards.
- Priority: memOp freeze > taken branch > load-use > default. A branch and a memOp cannot coexist in ME.
- MEMWAIT:
  - dmemReq=1; pcEn and all stage en=0.
  - On dmemAck: that cycle outputs the RUN default (pipe advances, no bubbles); next state=RUN, timer=0.
  - Otherwise timer increments. If dmemAck=0 while timer=TIMEOUT-1: next state=HALT and memErr is set.
  - Ack takes precedence over timeout in the same cycle.
- HALT:
  - All enables 0, dmemReq=0, memErr=1.
  - Exits only via rst_n. Asserting reset mid-MEMWAIT returns to RUN and drops dmemReq immediately.
- Timer width: clog2(TIMEOUT)+1 bits.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- Defined: stallCount increments (saturating at 16'hFFFF) on every post-reset cycle with pcEn=0, covering load-use, MEMWAIT and HALT. Cleared by reset.
- Undefined: stallCount is tied to 16'h0000 and no counter flops exist.

Test Plan:
- Reset check: rst_n=0 -> all en=0, dmemReq=0, memErr=0. Release with plain R-type ops -> all en=1, bubbles=0, pcSel=0.
- Load-use: exOpCode=6'h23, exRd=5'd8, idOpCode=6'h00, idRs=5'd8 -> one cycle of pcEn=0, ifidEn=0, idexBubble=1. Repeat with exRd=0 -> no stall.
- Branch: meOpCode=6'h04, meZero=1 -> pcSel=1, ifid/idex/exme bubbles=1 for 1 cycle. With meZero=0 -> no flush. BNE with meZero=0 -> flush.
- Memory wait: meOpCode=6'h2B, dmemAck low 3 cycles then high -> dmemReq high 4 cycles, pipe frozen 3 cycles, advances on the 4th, state back to RUN. HAZ_STALL_CNT_EN: stallCount=3.
- Watchdog: TIMEOUT=4, LW in ME, dmemAck never -> memErr=1 after 4 wait cycles, pipe stays frozen, dmemReq=0. rst_n pulse clears.
- Async reset mid-MEMWAIT: drop rst_n between clock edges -> dmemReq falls immediately, state=RUN after release.
